// File: rtl/id_scoreboard_pkg.sv
// Shared scoreboard constants and the per-stage forwarding record layout.
package id_scoreboard_pkg;

  localparam int NREG   = 32;
  localparam int NSRC   = 2;
  localparam int NFWD   = 3;
  localparam int CNT_W  = 2;
  localparam int DATA_W = 32;
  localparam int REG_W  = $clog2(NREG);

  typedef logic [REG_W-1:0] reg_idx_t;

  // Field order fixes the bit layout: data in the low bits, valid at the top.
  typedef struct packed {
    logic              valid;
    logic              we;
    reg_idx_t          dest;
    logic              data_ok;
    logic [DATA_W-1:0] data;
  } fwd_rec_t;

  localparam int FWD_REC_W = $bits(fwd_rec_t);

endpackage

// File: rtl/id_scoreboard_if.sv
// Decode-stage scoreboard bus: issue request, forwarding taps, retire and results.
interface id_scoreboard_if import id_scoreboard_pkg::*; ();

  logic                   issue_valid;
  logic                   issue_ready;
  logic                   issue_we;
  logic [REG_W-1:0]       issue_dest;
  logic [NSRC*REG_W-1:0]  issue_src;
  logic [NSRC-1:0]        issue_src_used;
  logic [NSRC*DATA_W-1:0] rf_rdata;
  logic [NFWD-1:0]        fwd_valid;
  logic [NFWD-1:0]        fwd_we;
  logic [NFWD*REG_W-1:0]  fwd_dest;
  logic [NFWD-1:0]        fwd_data_ok;
  logic [NFWD*DATA_W-1:0] fwd_data;
  logic                   retire_valid;
  logic [REG_W-1:0]       retire_dest;
  logic                   flush;
  logic [NSRC*DATA_W-1:0] src_value;
  logic                   sb_err;
  logic [31:0]            stall_cnt;

  modport master (
    output issue_valid, issue_we, issue_dest, issue_src, issue_src_used, rf_rdata,
           fwd_valid, fwd_we, fwd_dest, fwd_data_ok, fwd_data,
           retire_valid, retire_dest, flush,
    input  issue_ready, src_value, sb_err, stall_cnt
  );

  modport slave (
    input  issue_valid, issue_we, issue_dest, issue_src, issue_src_used, rf_rdata,
           fwd_valid, fwd_we, fwd_dest, fwd_data_ok, fwd_data,
           retire_valid, retire_dest, flush,
    output issue_ready, src_value, sb_err, stall_cnt
  );

endinterface

// File: rtl/id_scoreboard_sb_counter.sv
// Per-register in-flight writer counter: saturating up/down with synchronous clear.
module sb_counter import id_scoreboard_pkg::*; #(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // Simultaneous inc and dec cancel; the counter never wraps in either direction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                cnt <= '0;
    else if (clr)                               cnt <= '0;
    else if (inc && !dec && cnt != CNT_MAX)     cnt <= cnt + 1'b1;
    else if (dec && !inc && cnt != '0)          cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard: tracks in-flight writers, resolves operands
// through the forwarding network and stalls issue when a value is not yet available.
module id_scoreboard import id_scoreboard_pkg::*; (
  input logic           clk,
  input logic           resetn,
  id_scoreboard_if.slave bus
);

  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:1]            inc;
  logic [NREG-1:1]            dec;
  fwd_rec_t                   fwd [NFWD];
  logic [NSRC-1:0]            src_stall;
  logic                       dest_sat;
  logic                       ready;
  logic                       fire;
  logic                       err_set;
  logic                       sb_err_q;
  logic [31:0]                stall_q;

  assign cnt[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    sb_counter #(.W(CNT_W)) u_cnt (
      .clk    (clk),
      .resetn (resetn),
      .inc    (inc[r]),
      .dec    (dec[r]),
      .clr    (bus.flush),
      .cnt    (cnt[r])
    );
  end

  always_comb begin
    for (int i = 0; i < NFWD; i++) begin
      fwd[i] = '{valid:   bus.fwd_valid[i],
                 we:      bus.fwd_we[i],
                 dest:    bus.fwd_dest[i*REG_W +: REG_W],
                 data_ok: bus.fwd_data_ok[i],
                 data:    bus.fwd_data[i*DATA_W +: DATA_W]};
    end
  end

  // Youngest matching stage wins; a hazard with no matching stage waits for the regfile write.
  always_comb begin
    reg_idx_t          src_idx;
    logic              haz;
    logic              hit;
    logic              ok;
    logic [DATA_W-1:0] val;
    src_idx       = '0;
    haz           = 1'b0;
    hit           = 1'b0;
    ok            = 1'b0;
    val           = '0;
    src_stall     = '0;
    bus.src_value = '0;
    for (int s = 0; s < NSRC; s++) begin
      src_idx = bus.issue_src[s*REG_W +: REG_W];
      haz     = bus.issue_src_used[s] && src_idx != '0 && cnt[src_idx] != '0;
      val     = bus.rf_rdata[s*DATA_W +: DATA_W];
      hit     = 1'b0;
      ok      = 1'b0;
      for (int i = 0; i < NFWD; i++) begin
        if (haz && !hit && fwd[i].valid && fwd[i].we && fwd[i].dest == src_idx) begin
          hit = 1'b1;
          ok  = fwd[i].data_ok;
          val = fwd[i].data;
        end
      end
      src_stall[s]                      = haz && !(hit && ok);
      bus.src_value[s*DATA_W +: DATA_W] = val;
    end
  end

  assign dest_sat = bus.issue_we && bus.issue_dest != '0 && cnt[bus.issue_dest] == '1;
  assign ready    = resetn && !bus.flush && !dest_sat && !(|src_stall);
  assign fire     = bus.issue_valid && ready;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 1; r < NREG; r++) begin
      inc[r] = fire && bus.issue_we && bus.issue_dest == reg_idx_t'(r);
      dec[r] = bus.retire_valid && !bus.flush && bus.retire_dest == reg_idx_t'(r);
    end
  end

  // An issue to the same register in the same cycle covers a retire against a zero count.
  assign err_set = bus.retire_valid && !bus.flush && bus.retire_dest != '0 &&
                   cnt[bus.retire_dest] == '0 &&
                   !(fire && bus.issue_we && bus.issue_dest == bus.retire_dest);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sb_err_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      if (err_set)
        sb_err_q <= 1'b1;
      if (bus.issue_valid && !ready && !bus.flush)
        stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.issue_ready = ready;
  assign bus.sb_err      = sb_err_q;
  assign bus.stall_cnt   = stall_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: directed scenarios plus randomized traffic
// compared against a per-register in-flight count model.
module tb_id_scoreboard;
  import id_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  id_scoreboard_if bus();

  id_scoreboard dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  int                m_cnt [NREG];
  bit                m_err;
  logic [31:0]       m_stall;
  logic              m_ready;
  logic [DATA_W-1:0] m_val [NSRC];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
    m_err   = 1'b0;
    m_stall = '0;
  endtask

  // Index of the youngest stage currently writing register r, or -1.
  function automatic int findWriter(input int r);
    for (int i = 0; i < NFWD; i++)
      if (bus.fwd_valid[i] && bus.fwd_we[i] && int'(bus.fwd_dest[i*REG_W +: REG_W]) == r)
        return i;
    return -1;
  endfunction

  task automatic modelEval();
    int r;
    int w;
    m_ready = resetn && !bus.flush;
    if (bus.issue_we && bus.issue_dest != 0 && m_cnt[bus.issue_dest] >= (1 << CNT_W) - 1)
      m_ready = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      r        = int'(bus.issue_src[s*REG_W +: REG_W]);
      m_val[s] = bus.rf_rdata[s*DATA_W +: DATA_W];
      if (bus.issue_src_used[s] && r != 0 && m_cnt[r] > 0) begin
        w = findWriter(r);
        if (w < 0) m_ready = 1'b0;
        else begin
          m_val[s] = bus.fwd_data[w*DATA_W +: DATA_W];
          if (!bus.fwd_data_ok[w]) m_ready = 1'b0;
        end
      end
    end
  endtask

  task automatic modelCommit();
    int d;
    int rd;
    bit incr;
    if (!resetn) return;
    if (bus.issue_valid && !m_ready && !bus.flush) m_stall = m_stall + 32'd1;
    if (bus.flush) begin
      for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
      return;
    end
    d    = int'(bus.issue_dest);
    rd   = int'(bus.retire_dest);
    incr = bus.issue_valid && m_ready && bus.issue_we && d != 0;
    if (bus.retire_valid && rd != 0) begin
      if (incr && d == rd) incr = 1'b0;
      else if (m_cnt[rd] == 0) m_err = 1'b1;
      else m_cnt[rd]--;
    end
    if (incr) m_cnt[d]++;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic applyStimulus(input string tag);
    #1;
    modelEval();
    checkOutput({tag, ".ready"}, 32'(bus.issue_ready), 32'(m_ready));
    for (int s = 0; s < NSRC; s++)
      checkOutput($sformatf("%s.src%0d", tag, s), bus.src_value[s*DATA_W +: DATA_W], m_val[s]);
    checkOutput({tag, ".sb_err"}, 32'(bus.sb_err), 32'(m_err));
    checkOutput({tag, ".stall"}, bus.stall_cnt, m_stall);
    @(posedge clk);
    modelCommit();
    @(negedge clk);
  endtask

  task automatic setIdle();
    bus.issue_valid    = 1'b0;
    bus.issue_we       = 1'b0;
    bus.issue_dest     = '0;
    bus.issue_src      = '0;
    bus.issue_src_used = '0;
    bus.rf_rdata       = {$urandom, $urandom};
    bus.fwd_valid      = '0;
    bus.fwd_we         = '0;
    bus.fwd_dest       = '0;
    bus.fwd_data_ok    = '0;
    bus.fwd_data       = '0;
    bus.retire_valid   = 1'b0;
    bus.retire_dest    = '0;
    bus.flush          = 1'b0;
  endtask

  task automatic setIssue(input bit v, input bit we, input int dest,
                          input int s0, input bit u0, input int s1, input bit u1);
    bus.issue_valid    = v;
    bus.issue_we       = we;
    bus.issue_dest     = REG_W'(dest);
    bus.issue_src      = {REG_W'(s1), REG_W'(s0)};
    bus.issue_src_used = {u1, u0};
  endtask

  task automatic setFwd(input int i, input bit v, input bit we, input int dest,
                        input bit ok, input logic [DATA_W-1:0] data);
    bus.fwd_valid[i]                = v;
    bus.fwd_we[i]                   = we;
    bus.fwd_dest[i*REG_W +: REG_W]  = REG_W'(dest);
    bus.fwd_data_ok[i]              = ok;
    bus.fwd_data[i*DATA_W +: DATA_W] = data;
  endtask

  task automatic setRetire(input int r);
    bus.retire_valid = 1'b1;
    bus.retire_dest  = REG_W'(r);
  endtask

  initial begin
    int r;
    modelReset();
    setIdle();
    resetn = 1'b0;
    @(negedge clk);

    setIssue(1, 1, 5, 0, 0, 0, 0);
    applyStimulus("in_reset");
    resetn = 1'b1;

    // Add to r5, then a consumer forwarded from stage 0.
    setIdle(); setIssue(1, 1, 5, 0, 0, 0, 0);
    applyStimulus("first_issue");
    setIdle(); setIssue(1, 0, 0, 5, 1, 0, 0);
    setFwd(0, 1, 1, 5, 1, 32'h1234);
    #1;
    checkOutput("fwd_ex.ready", 32'(bus.issue_ready), 32'd1);
    checkOutput("fwd_ex.value", bus.src_value[DATA_W-1:0], 32'h1234);
    applyStimulus("fwd_ex");
    setIdle(); setRetire(5);
    applyStimulus("retire_r5");

    // Load to r7 not ready in stage 0, then available in stage 1.
    setIdle(); setIssue(1, 1, 7, 0, 0, 0, 0);
    applyStimulus("load_issue");
    setIdle(); setIssue(1, 0, 0, 0, 0, 7, 1);
    setFwd(0, 1, 1, 7, 0, 32'h0);
    #1;
    checkOutput("load_use.ready", 32'(bus.issue_ready), 32'd0);
    applyStimulus("load_use");
    checkOutput("load_use.stall", bus.stall_cnt, 32'd1);
    setIdle(); setIssue(1, 0, 0, 0, 0, 7, 1);
    setFwd(1, 1, 1, 7, 1, 32'hDEAD);
    #1;
    checkOutput("load_fwd.ready", 32'(bus.issue_ready), 32'd1);
    checkOutput("load_fwd.value", bus.src_value[2*DATA_W-1:DATA_W], 32'hDEAD);
    applyStimulus("load_fwd");
    setIdle(); setRetire(7);
    applyStimulus("retire_r7");

    // Saturate r3.
    for (int k = 0; k < 3; k++) begin
      setIdle(); setIssue(1, 1, 3, 0, 0, 0, 0);
      applyStimulus("fill_r3");
    end
    setIdle(); setIssue(1, 1, 3, 0, 0, 0, 0);
    #1;
    checkOutput("sat_r3.ready", 32'(bus.issue_ready), 32'd0);
    applyStimulus("sat_r3");
    setIdle(); setIssue(1, 1, 3, 0, 0, 0, 0); setRetire(3);
    applyStimulus("sat_r3_retire");
    setIdle(); setIssue(1, 1, 3, 0, 0, 0, 0);
    #1;
    checkOutput("unsat_r3.ready", 32'(bus.issue_ready), 32'd1);
    applyStimulus("unsat_r3");
    for (int k = 0; k < 3; k++) begin
      setIdle(); setRetire(3);
      applyStimulus("drain_r3");
    end

    // Randomized traffic on a small register window so hazards are frequent.
    for (int n = 0; n < 400; n++) begin
      setIdle();
      setIssue(($urandom % 4) != 0, $urandom % 2, $urandom % 8,
               $urandom % 8, $urandom % 2, $urandom % 8, $urandom % 2);
      for (int i = 0; i < NFWD; i++)
        setFwd(i, $urandom % 2, ($urandom % 4) != 0, $urandom % 8, ($urandom % 4) != 0, $urandom);
      r = 1 + ($urandom % 7);
      if (m_cnt[r] > 0 && ($urandom % 2) == 1) setRetire(r);
      else if (($urandom % 20) == 0) setRetire(0);
      bus.flush = ($urandom % 50) == 0;
      applyStimulus("rand");
    end
    setIdle(); bus.flush = 1'b1;
    applyStimulus("rand_flush");

    // Flush with a concurrent issue and retire while r4 has two writers.
    setIdle(); setIssue(1, 1, 4, 0, 0, 0, 0);
    applyStimulus("fill_r4");
    setIdle(); setIssue(1, 1, 4, 0, 0, 0, 0);
    applyStimulus("fill_r4");
    setIdle(); setIssue(1, 1, 4, 0, 0, 0, 0); setRetire(4);
    bus.flush = 1'b1;
    #1;
    checkOutput("flush.ready", 32'(bus.issue_ready), 32'd0);
    applyStimulus("flush");
    setIdle(); setIssue(1, 0, 0, 4, 1, 0, 0);
    bus.rf_rdata[DATA_W-1:0] = 32'hCAFE;
    #1;
    checkOutput("post_flush.ready", 32'(bus.issue_ready), 32'd1);
    checkOutput("post_flush.value", bus.src_value[DATA_W-1:0], 32'hCAFE);
    applyStimulus("post_flush");

    // Issue and retire of r9 cancel; then an unmatched retire of r10.
    setIdle(); setIssue(1, 1, 9, 0, 0, 0, 0);
    applyStimulus("issue_r9");
    setIdle(); setIssue(1, 1, 9, 0, 0, 0, 0); setRetire(9);
    applyStimulus("issue_retire_r9");
    setIdle(); setIssue(1, 0, 0, 9, 1, 0, 0);
    #1;
    checkOutput("r9_pending.ready", 32'(bus.issue_ready), 32'd0);
    applyStimulus("r9_pending");
    setIdle(); setRetire(9);
    applyStimulus("retire_r9");
    setIdle(); setRetire(10);
    applyStimulus("retire_r10");
    checkOutput("sb_err.set", 32'(bus.sb_err), 32'd1);
    for (int k = 0; k < 3; k++) begin
      setIdle();
      applyStimulus("sb_err_hold");
    end
    checkOutput("sb_err.sticky", 32'(bus.sb_err), 32'd1);

    // Asynchronous reset between edges with r6 in flight.
    setIdle(); setIssue(1, 1, 6, 0, 0, 0, 0);
    applyStimulus("issue_r6");
    setIdle(); setIssue(1, 0, 0, 6, 1, 0, 0);
    #3;
    resetn = 1'b0;
    #1;
    checkOutput("async_rst.sb_err", 32'(bus.sb_err), 32'd0);
    checkOutput("async_rst.stall", bus.stall_cnt, 32'd0);
    checkOutput("async_rst.ready", 32'(bus.issue_ready), 32'd0);
    modelReset();
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus("after_rst");
    setIdle(); setIssue(1, 1, 6, 6, 1, 0, 0);
    applyStimulus("after_rst_issue");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
ID_SCOREBOARD -- requirements
Module: id_scoreboard

Interface
REQ-001 Parameters SHALL be: NREG=32 (architectural registers); NSRC=2 (source operands per instruction); NFWD=3 (forwarding stages, index 0 youngest = EX); CNT_W=2 (per-register in-flight counter width); DATA_W=32.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 issue_valid  in  1  decode holds an instruction.
REQ-005 issue_ready  out  1  instruction may leave decode this cycle.
REQ-006 issue_we / issue_dest  in  1 / 5  instruction writes GR issue_dest.
REQ-007 issue_src / issue_src_used  in  NSRC*5 / NSRC  source register numbers and their used flags.
REQ-008 rf_rdata  in  NSRC*DATA_W  regfile read data per source.
REQ-009 fwd_valid / fwd_we / fwd_dest  in  NFWD / NFWD / NFWD*5  per-stage writer info.
REQ-010 fwd_data_ok / fwd_data  in  NFWD / NFWD*DATA_W  result available (0 for load or unfinished div in that stage) and value.
REQ-011 retire_valid / retire_dest  in  1 / 5  WB register write committed.
REQ-012 flush  in  1  all in-flight instructions after WB discarded.
REQ-013 src_value  out  NSRC*DATA_W  resolved operand values.
REQ-014 sb_err  out  1  sticky: retire to a register with zero count.
REQ-015 stall_cnt  out  32  count of cycles with issue_valid=1 and issue_ready=0.

Function
REQ-016 Per register r (1..NREG-1), cnt[r] SHALL track in-flight writers; r0 never counted or matched.
REQ-017 Issue fire = issue_valid & issue_ready; on fire with issue_we & dest!=0, cnt[dest] SHALL increment next edge.
REQ-018 retire_valid with dest!=0 SHALL decrement cnt[dest]; same-register fire and retire in one cycle SHALL leave cnt unchanged.
REQ-019 Retire to a register with cnt=0 (no simultaneous increment) SHALL leave cnt at 0 and set sb_err.
REQ-020 Source s SHALL be hazardous when issue_src_used[s], src!=0, and cnt[src]!=0.
REQ-021 Hazardous source SHALL select fwd_data of the lowest-index stage with fwd_valid & fwd_we & fwd_dest==src; if none match, rf_rdata.
REQ-022 Non-hazardous or unused source SHALL take rf_rdata unchanged.
REQ-023 issue_ready SHALL be 0 when any hazardous source's selected match has fwd_data_ok=0, or is hazardous with no stage matching (value only in WB-retire path), or when issue_we & dest!=0 & cnt[dest] = 2^CNT_W-1 (saturation).
REQ-024 Retire in the same cycle SHALL NOT bypass into src_value; retire-only hazards stall one cycle (regfile write-then-read).
REQ-025 issue_ready, src_value SHALL be combinational from current inputs and state; zero-cycle latency.
REQ-026 flush SHALL clear all cnt to 0 next edge, force issue_ready=0 that cycle, and ignore same-cycle issue and retire updates.
REQ-027 stall_cnt SHALL increment when issue_valid & ~issue_ready & ~flush, wrapping at 2^32.

Reset
REQ-028 On resetn=0: all cnt=0, sb_err=0, stall_cnt=0, immediately and independent of clk.
REQ-029 During reset issue_ready SHALL be 0; first issue accepted on first edge after deassertion.
REQ-030 Reset mid-operation SHALL discard all in-flight tracking; no state persists.

Structure
REQ-031 NREG, DATA_W, forwarding-bus field offsets, and the per-stage forward record layout SHALL live in the shared myCPU header/package.
REQ-032 One sub-module sb_counter (per-register up/down saturating counter with inc, dec, clr) SHALL be instantiated NREG-1 times.
REQ-033 The forwarding mux SHALL be a parametrised priority loop over NFWD, no hard-coded stage count.

Verification
REQ-034 Issue add r5 (cnt 0->1), next instr uses r5 with stage0 match, data_ok=1, fwd_data=0x1234 -> issue_ready=1, src_value=0x1234.
REQ-035 Load to r7 in stage0 (data_ok=0), dependent instr -> issue_ready=0, stall_cnt +1; next cycle stage1 match data_ok=1 value 0xDEAD -> ready=1, value 0xDEAD.
REQ-036 Three back-to-back writes to r3 (CNT_W=2, cnt=3), fourth write to r3 -> issue_ready=0 until a retire of r3.
REQ-037 Same cycle issue writes r9 and retire r9 with cnt=1 -> cnt stays 1; retire r10 with cnt=0 -> sb_err=1 and stays 1.
REQ-038 cnt[4]=2, flush asserted with concurrent issue to r4 -> next cycle all cnt=0, source r4 reads rf_rdata.
REQ-039 Assert resetn=0 between edges with cnt nonzero -> outputs cleared without clock edge.
